// File: rtl/bitslam_sequencer.sv
// Step sequencer and host arbiter for the two-voice bitslam register bus.
// Plays per-step divider pairs into voice0/voice1 at a programmable tempo and interleaves host beats.
module bitslam_sequencer #(
    parameter int STEPS   = 16,
    parameter int STEP_W  = 4,
    parameter int TEMPO_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic [TEMPO_W-1:0] i_tempo_div,
    input  logic [STEP_W-1:0]  i_seq_len,
    input  logic               i_pat_we,
    input  logic [STEP_W-1:0]  i_pat_addr,
    input  logic [11:0]        i_pat_wdata,
    input  logic               i_host_req,
    input  logic               i_host_sel,
    input  logic [5:0]         i_host_data,
    output logic               o_host_ack,
    output logic               o_bus_sel,
    output logic [5:0]         o_bus_data,
    output logic [STEP_W-1:0]  o_step,
    output logic               o_busy,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_A0,
        S_D0,
        S_A1,
        S_D1,
        S_RA
    } state_t;

    localparam logic [STEP_W:0] LP_STEPS = (STEP_W + 1)'(STEPS);

    state_t             r_state;
    state_t             w_next;
    logic [TEMPO_W-1:0] r_count;
    logic               r_pending;
    logic               r_overrun;
    logic [1:0]         r_shadow;
    logic [STEP_W-1:0]  r_step;
    logic [11:0]        r_ram [STEPS];
    logic               r_bus_sel;
    logic [5:0]         r_bus_data;
    logic               r_host_ack;
    logic               r_busy;

    logic               w_tick;
    logic               w_consume;
    logic               w_shadow_we;
    logic               w_bus_sel;
    logic [5:0]         w_bus_data;
    logic               w_host_ack;
    logic [11:0]        w_rd;
    logic [STEP_W:0]    w_eff_len;
    logic [STEP_W:0]    w_step_inc;
    logic [STEP_W-1:0]  w_step_next;

    assign w_tick      = i_run && (r_count == i_tempo_div);
    assign w_rd        = r_ram[r_step];
    assign w_eff_len   = (i_seq_len == '0) ? LP_STEPS : {1'b0, i_seq_len};
    assign w_step_inc  = {1'b0, r_step} + (STEP_W + 1)'(1);
    // The >= compare also folds a step left beyond a shrunken seq_len back to 0.
    assign w_step_next = (w_step_inc >= w_eff_len) ? '0 : w_step_inc[STEP_W-1:0];
    assign w_consume   = (r_state == S_IDLE) && !i_host_req && r_pending;
    assign w_shadow_we = (r_state == S_IDLE) && i_host_req && !i_host_sel;

    always_ff @(posedge i_clk) begin
        if (i_pat_we) begin
            r_ram[i_pat_addr] <= i_pat_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!i_run || w_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + TEMPO_W'(1);
            end
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
            if (w_tick && r_pending) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Bus outputs are decoded from the next state so each beat is visible in its own state's cycle.
    always_comb begin
        w_next     = r_state;
        w_bus_sel  = 1'b0;
        w_bus_data = 6'h00;
        w_host_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_host_req) begin
                    w_next = S_HOST;
                end else if (r_pending) begin
                    w_next = S_A0;
                end
            end
            S_HOST:  w_next = S_IDLE;
            S_A0:    w_next = S_D0;
            S_D0:    w_next = S_A1;
            S_A1:    w_next = S_D1;
            S_D1:    w_next = S_RA;
            S_RA:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        case (w_next)
            S_IDLE:  w_bus_data = {4'b0, r_shadow};
            S_HOST: begin
                w_bus_sel  = i_host_sel;
                w_bus_data = i_host_data;
                w_host_ack = 1'b1;
            end
            S_A0:    w_bus_data = 6'h00;
            S_D0: begin
                w_bus_sel  = 1'b1;
                w_bus_data = w_rd[5:0];
            end
            S_A1:    w_bus_data = 6'h02;
            S_D1: begin
                w_bus_sel  = 1'b1;
                w_bus_data = w_rd[11:6];
            end
            S_RA:    w_bus_data = {4'b0, r_shadow};
            default: w_bus_data = 6'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_bus_sel  <= 1'b0;
            r_bus_data <= 6'h00;
            r_host_ack <= 1'b0;
            r_busy     <= 1'b0;
            r_shadow   <= 2'b00;
            r_step     <= '0;
        end else begin
            r_state    <= w_next;
            r_bus_sel  <= w_bus_sel;
            r_bus_data <= w_bus_data;
            r_host_ack <= w_host_ack;
            r_busy     <= (w_next != S_IDLE);
            if (w_shadow_we) begin
                r_shadow <= i_host_data[1:0];
            end
            if (r_state == S_D1) begin
                r_step <= w_step_next;
            end
        end
    end

    assign o_host_ack = r_host_ack;
    assign o_bus_sel  = r_bus_sel;
    assign o_bus_data = r_bus_data;
    assign o_step     = r_step;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_bitslam_sequencer.sv
// Directed bench for bitslam_sequencer: host beat table, burst timing, step wrap,
// arbitration corners, overrun threshold and reset mid-burst.
module tb_bitslam_sequencer;

    localparam int STEPS   = 16;
    localparam int STEP_W  = 4;
    localparam int TEMPO_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic [TEMPO_W-1:0] tempoDiv;
    logic [STEP_W-1:0]  seqLen;
    logic               patWe;
    logic [STEP_W-1:0]  patAddr;
    logic [11:0]        patWdata;
    logic               hostReq;
    logic               hostSel;
    logic [5:0]         hostData;
    logic               hostAck;
    logic               busSel;
    logic [5:0]         busData;
    logic [STEP_W-1:0]  step;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       sel;
        logic [5:0] data;
        logic       expSel;
        logic [5:0] expData;
        logic [5:0] expIdle;
    } hostVec_t;

    hostVec_t vecs [6];

    bitslam_sequencer #(.STEPS(STEPS), .STEP_W(STEP_W), .TEMPO_W(TEMPO_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_run       (run),
        .i_tempo_div (tempoDiv),
        .i_seq_len   (seqLen),
        .i_pat_we    (patWe),
        .i_pat_addr  (patAddr),
        .i_pat_wdata (patWdata),
        .i_host_req  (hostReq),
        .i_host_sel  (hostSel),
        .i_host_data (hostData),
        .o_host_ack  (hostAck),
        .o_bus_sel   (busSel),
        .o_bus_data  (busData),
        .o_step      (step),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkBeat(input string name, input logic expSel, input logic [5:0] expData,
                             input logic expBusy);
        checkOutput({name, "_sel"},  32'(busSel),  32'(expSel));
        checkOutput({name, "_data"}, 32'(busData), 32'(expData));
        checkOutput({name, "_busy"}, 32'(busy),    32'(expBusy));
    endtask

    task automatic applyStimulus(input hostVec_t v, input int idx);
        hostReq  = 1'b1;
        hostSel  = v.sel;
        hostData = v.data;
        stepClk();
        checkOutput($sformatf("host%0d_ack", idx), 32'(hostAck), 32'd1);
        checkBeat($sformatf("host%0d_beat", idx), v.expSel, v.expData, 1'b1);
        hostReq = 1'b0;
        stepClk();
        checkOutput($sformatf("host%0d_ackdrop", idx), 32'(hostAck), 32'd0);
        checkBeat($sformatf("host%0d_idle", idx), 1'b0, v.expIdle, 1'b0);
    endtask

    task automatic writeRam(input int addr, input logic [11:0] data);
        patWe    = 1'b1;
        patAddr  = STEP_W'(addr);
        patWdata = data;
        stepClk();
        patWe = 1'b0;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        run     = 1'b0;
        hostReq = 1'b0;
        patWe   = 1'b0;
        stepClk();
        stepClk();
        rst = 1'b0;
    endtask

    task automatic waitBurst(input string name, output int n);
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            stepClk();
            n++;
        end
        checkOutput({name, "_started"}, 32'(busy), 32'd1);
    endtask

    // Called with the FSM in A0; leaves it in the IDLE cycle after RA.
    task automatic checkBurst(input string name, input int a0Step, input logic [5:0] v0,
                              input logic [5:0] v1, input logic [5:0] shadowData, input int raStep);
        checkBeat({name, "_a0"}, 1'b0, 6'h00, 1'b1);
        checkOutput({name, "_a0step"}, 32'(step), 32'(a0Step));
        stepClk();
        checkBeat({name, "_d0"}, 1'b1, v0, 1'b1);
        stepClk();
        checkBeat({name, "_a1"}, 1'b0, 6'h02, 1'b1);
        stepClk();
        checkBeat({name, "_d1"}, 1'b1, v1, 1'b1);
        stepClk();
        checkBeat({name, "_ra"}, 1'b0, shadowData, 1'b1);
        checkOutput({name, "_rastep"}, 32'(step), 32'(raStep));
        stepClk();
        checkBeat({name, "_idle"}, 1'b0, shadowData, 1'b0);
    endtask

    initial begin
        int n;
        hostVec_t hv;

        vecs[0] = '{1'b0, 6'h02, 1'b0, 6'h02, 6'h02};
        vecs[1] = '{1'b1, 6'h15, 1'b1, 6'h15, 6'h02};
        vecs[2] = '{1'b0, 6'h3D, 1'b0, 6'h3D, 6'h01};
        vecs[3] = '{1'b1, 6'h2A, 1'b1, 6'h2A, 6'h01};
        vecs[4] = '{1'b0, 6'h00, 1'b0, 6'h00, 6'h00};
        vecs[5] = '{1'b1, 6'h3F, 1'b1, 6'h3F, 6'h00};

        rst      = 1'b1;
        run      = 1'b0;
        tempoDiv = 16'd9;
        seqLen   = '0;
        patWe    = 1'b0;
        patAddr  = '0;
        patWdata = '0;
        hostReq  = 1'b0;
        hostSel  = 1'b0;
        hostData = 6'h00;

        $display("[TB] reset values");
        stepClk();
        stepClk();
        checkOutput("rst_ack", 32'(hostAck), 32'd0);
        checkBeat("rst", 1'b0, 6'h00, 1'b0);
        checkOutput("rst_step", 32'(step), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < STEPS; i++) begin
            writeRam(i, {6'(i + 32), 6'(i)});
        end

        $display("[TB] host beat table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] burst timing and data");
        doReset();
        writeRam(0, 12'hFC5);
        writeRam(1, 12'h462);
        hv = '{1'b0, 6'h03, 1'b0, 6'h03, 6'h03};
        applyStimulus(hv, 9);
        tempoDiv = 16'd9;
        seqLen   = 4'd2;
        run      = 1'b1;
        waitBurst("burst1", n);
        checkOutput("burst1_latency", n, 32'd11);
        checkBurst("burst1", 0, 6'h05, 6'h3F, 6'h03, 1);
        waitBurst("burst2", n);
        checkOutput("burst2_latency", n, 32'd5);
        checkBurst("burst2", 1, 6'h22, 6'h11, 6'h03, 0);
        checkOutput("burst_overrun", 32'(overrun), 32'd0);
        run = 1'b0;
        writeRam(0, {6'd32, 6'd0});
        writeRam(1, {6'd33, 6'd1});

        $display("[TB] seq_len 3 and run drop mid-burst");
        doReset();
        seqLen = 4'd3;
        run    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitBurst($sformatf("len3_%0d", k), n);
            checkBurst($sformatf("len3_%0d", k), k % 3, 6'(k % 3), 6'((k % 3) + 32), 6'h00, (k + 1) % 3);
        end
        waitBurst("rundrop", n);
        run = 1'b0;
        checkBurst("rundrop", 1, 6'd1, 6'd33, 6'h00, 2);
        repeat (30) stepClk();
        checkOutput("rundrop_busy", 32'(busy), 32'd0);
        checkOutput("rundrop_step", 32'(step), 32'd2);

        $display("[TB] seq_len 0 full wrap and shrink");
        doReset();
        seqLen = 4'd0;
        run    = 1'b1;
        for (int k = 0; k < 21; k++) begin
            waitBurst($sformatf("len16_%0d", k), n);
            checkBurst($sformatf("len16_%0d", k), k % 16, 6'(k % 16), 6'((k % 16) + 32), 6'h00,
                       (k + 1) % 16);
        end
        seqLen = 4'd3;
        waitBurst("shrink", n);
        checkBurst("shrink", 5, 6'd5, 6'd37, 6'h00, 0);
        run = 1'b0;

        $display("[TB] host versus tick and host during burst");
        doReset();
        tempoDiv = 16'd9;
        run      = 1'b1;
        repeat (10) stepClk();
        checkOutput("coll_pre_busy", 32'(busy), 32'd0);
        hostReq  = 1'b1;
        hostSel  = 1'b1;
        hostData = 6'h2B;
        stepClk();
        checkOutput("coll_ack", 32'(hostAck), 32'd1);
        checkBeat("coll_host", 1'b1, 6'h2B, 1'b1);
        hostReq = 1'b0;
        stepClk();
        checkOutput("coll_gap_ack", 32'(hostAck), 32'd0);
        checkOutput("coll_gap_busy", 32'(busy), 32'd0);
        stepClk();
        checkBeat("coll_a0", 1'b0, 6'h00, 1'b1);
        run      = 1'b0;
        hostReq  = 1'b1;
        hostSel  = 1'b0;
        hostData = 6'h01;
        for (int j = 0; j < 4; j++) begin
            stepClk();
            checkOutput($sformatf("wait_ack_%0d", j), 32'(hostAck), 32'd0);
            checkOutput($sformatf("wait_busy_%0d", j), 32'(busy), 32'd1);
        end
        stepClk();
        checkOutput("wait_idle_ack", 32'(hostAck), 32'd0);
        checkOutput("wait_idle_busy", 32'(busy), 32'd0);
        stepClk();
        checkOutput("wait_host_ack", 32'(hostAck), 32'd1);
        checkBeat("wait_host", 1'b0, 6'h01, 1'b1);
        hostReq = 1'b0;
        stepClk();
        checkBeat("wait_after", 1'b0, 6'h01, 1'b0);

        $display("[TB] overrun threshold");
        doReset();
        tempoDiv = 16'd5;
        run      = 1'b1;
        repeat (60) stepClk();
        checkOutput("ovr_div5", 32'(overrun), 32'd0);
        doReset();
        tempoDiv = 16'd4;
        run      = 1'b1;
        repeat (60) stepClk();
        checkOutput("ovr_div4", 32'(overrun), 32'd1);
        doReset();
        tempoDiv = 16'd2;
        run      = 1'b1;
        repeat (20) stepClk();
        checkOutput("ovr_div2", 32'(overrun), 32'd1);
        run = 1'b0;
        repeat (20) stepClk();
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        $display("[TB] reset mid-burst");
        tempoDiv = 16'd9;
        run      = 1'b1;
        waitBurst("rstmid", n);
        stepClk();
        checkBeat("rstmid_d0", 1'b1, 6'(step), 1'b1);
        rst = 1'b1;
        run = 1'b0;
        stepClk();
        checkBeat("rstmid_1", 1'b0, 6'h00, 1'b0);
        checkOutput("rstmid_ack", 32'(hostAck), 32'd0);
        checkOutput("rstmid_step", 32'(step), 32'd0);
        checkOutput("rstmid_overrun", 32'(overrun), 32'd0);
        stepClk();
        checkOutput("rstmid_2_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) stepClk();
        checkOutput("rstmid_after_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_after_step", 32'(step), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
